// File: rtl/fault_inject_sequencer.sv
// rtl/fault_inject_sequencer.sv - timed register-file fault injector (optional FI_STUCK_AT_EN adds stuck-at modes)
module fault_inject_sequencer #(
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5,
    parameter int DELAY_WIDTH    = 32,
    parameter int COUNT_WIDTH    = 16
) (
    input  logic                      CLK,
    input  logic                      RSTn,
    input  logic                      cfg_arm,
    input  logic                      cfg_abort,
    input  logic [REG_ADDR_WIDTH-1:0] cfg_target_reg,
    input  logic [DATA_WIDTH-1:0]     cfg_mask,
    input  logic [DELAY_WIDTH-1:0]    cfg_delay,
`ifdef FI_STUCK_AT_EN
    input  logic [1:0]                cfg_mode,
`endif
    input  logic                      cpu_running,
    output logic                      inj_stall,
    output logic [REG_ADDR_WIDTH-1:0] regfile_addr,
    input  logic [DATA_WIDTH-1:0]     regfile_read_data,
    output logic                      regfile_write_enable,
    output logic [DATA_WIDTH-1:0]     regfile_write_data,
    output logic                      busy,
    output logic                      done,
    output logic                      err,
    output logic [DATA_WIDTH-1:0]     orig_value,
    output logic [COUNT_WIDTH-1:0]    inj_count
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_COUNT   = 3'd1,
        S_STALL   = 3'd2,
        S_READ    = 3'd3,
        S_WRITE   = 3'd4,
        S_RELEASE = 3'd5
    } state_t;

    state_t                    state_q, state_d;
    logic [DELAY_WIDTH-1:0]    delay_q, delay_d;
    logic [REG_ADDR_WIDTH-1:0] target_q, target_d;
    logic [DATA_WIDTH-1:0]     mask_q, mask_d;
    logic [DATA_WIDTH-1:0]     orig_q, orig_d;
    logic [COUNT_WIDTH-1:0]    count_q, count_d;
    logic                      err_q, err_d;
    logic                      arm_illegal;
    logic [DATA_WIDTH-1:0]     fault_value;

`ifdef FI_STUCK_AT_EN
    logic [1:0]                mode_q, mode_d;

    // Register 0 is hardwired, and mode 3 has no defined fault type.
    assign arm_illegal = (cfg_target_reg == '0) || (cfg_mode == 2'd3);

    // Fault type selected by the mode latched at arm time.
    always_comb begin
        fault_value = orig_q ^ mask_q;
        case (mode_q)
            2'd1:    fault_value = orig_q | mask_q;
            2'd2:    fault_value = orig_q & ~mask_q;
            default: fault_value = orig_q ^ mask_q;
        endcase
    end
`else
    // Register 0 is hardwired, so corrupting it is meaningless.
    assign arm_illegal = (cfg_target_reg == '0);

    assign fault_value = orig_q ^ mask_q;
`endif

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            state_q  <= S_IDLE;
            delay_q  <= '0;
            target_q <= '0;
            mask_q   <= '0;
            orig_q   <= '0;
            count_q  <= '0;
            err_q    <= 1'b0;
`ifdef FI_STUCK_AT_EN
            mode_q   <= 2'd0;
`endif
        end else begin
            state_q  <= state_d;
            delay_q  <= delay_d;
            target_q <= target_d;
            mask_q   <= mask_d;
            orig_q   <= orig_d;
            count_q  <= count_d;
            err_q    <= err_d;
`ifdef FI_STUCK_AT_EN
            mode_q   <= mode_d;
`endif
        end
    end

    // Next-state logic; config is only sampled in IDLE so a busy arm cannot disturb a sequence.
    always_comb begin
        state_d  = state_q;
        delay_d  = delay_q;
        target_d = target_q;
        mask_d   = mask_q;
        orig_d   = orig_q;
        count_d  = count_q;
        err_d    = err_q;
`ifdef FI_STUCK_AT_EN
        mode_d   = mode_q;
`endif
        case (state_q)
            S_IDLE: begin
                // Arm wins over a simultaneous abort; abort has nothing to cancel here.
                if (cfg_arm) begin
                    if (arm_illegal) begin
                        err_d = 1'b1;
                    end else begin
                        err_d    = 1'b0;
                        target_d = cfg_target_reg;
                        mask_d   = cfg_mask;
                        delay_d  = cfg_delay;
`ifdef FI_STUCK_AT_EN
                        mode_d   = cfg_mode;
`endif
                        state_d  = S_COUNT;
                    end
                end
            end
            S_COUNT: begin
                // Abort beats the zero check; only CPU-running cycles consume the delay.
                if (cfg_abort) begin
                    state_d = S_IDLE;
                end else if (delay_q == '0) begin
                    state_d = S_STALL;
                end else if (cpu_running) begin
                    delay_d = delay_q - DELAY_WIDTH'(1);
                end
            end
            S_STALL: begin
                // Settle cycle so any in-flight instruction retires before the read.
                state_d = S_READ;
            end
            S_READ: begin
                orig_d  = regfile_read_data;
                state_d = S_WRITE;
            end
            S_WRITE: begin
                state_d = S_RELEASE;
            end
            S_RELEASE: begin
                count_d = count_q + COUNT_WIDTH'(1);
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Outputs decoded from the state register only, keeping cfg_* off every output path.
    always_comb begin
        inj_stall            = 1'b0;
        regfile_addr         = '0;
        regfile_write_enable = 1'b0;
        regfile_write_data   = '0;
        done                 = 1'b0;
        case (state_q)
            S_STALL: begin
                inj_stall = 1'b1;
            end
            S_READ: begin
                inj_stall    = 1'b1;
                regfile_addr = target_q;
            end
            S_WRITE: begin
                inj_stall            = 1'b1;
                regfile_addr         = target_q;
                regfile_write_enable = 1'b1;
                regfile_write_data   = fault_value;
            end
            S_RELEASE: begin
                done = 1'b1;
            end
            default: begin
                inj_stall = 1'b0;
            end
        endcase
    end

    assign busy       = (state_q != S_IDLE);
    assign err        = err_q;
    assign orig_value = orig_q;
    assign inj_count  = count_q;

endmodule

// File: tb/tb_fault_inject_sequencer.sv
// tb/tb_fault_inject_sequencer.sv - directed self-checking bench for fault_inject_sequencer
module tb_fault_inject_sequencer;

    logic        CLK = 1'b0;
    logic        RSTn;
    logic        cfg_arm;
    logic        cfg_abort;
    logic [4:0]  cfg_target_reg;
    logic [31:0] cfg_mask;
    logic [31:0] cfg_delay;
`ifdef FI_STUCK_AT_EN
    logic [1:0]  cfg_mode;
`endif
    logic        cpu_running;
    logic        inj_stall;
    logic [4:0]  regfile_addr;
    logic [31:0] regfile_read_data;
    logic        regfile_write_enable;
    logic [31:0] regfile_write_data;
    logic        busy;
    logic        done;
    logic        err;
    logic [31:0] orig_value;
    logic [15:0] inj_count;

    logic        w_inj_stall;
    logic [4:0]  w_regfile_addr;
    logic [31:0] w_regfile_read_data;
    logic        w_regfile_write_enable;
    logic [31:0] w_regfile_write_data;
    logic        w_busy;
    logic        w_done;
    logic        w_err;
    logic [31:0] w_orig_value;
    logic [2:0]  w_inj_count;

    logic [31:0] rf_val [32];
    int          vectors = 0;
    int          miscompares = 0;
    int          wr_cnt = 0;
    int          done_cnt = 0;
    logic [4:0]  wr_addr = '0;
    logic [31:0] wr_data = '0;
    int          exp_cnt = 0;
    int          wc;
    int          dc;
    logic        pat [7];

    always #5 CLK = ~CLK;

    assign regfile_read_data   = rf_val[regfile_addr];
    assign w_regfile_read_data = rf_val[w_regfile_addr];

    fault_inject_sequencer dut (
        .CLK(CLK), .RSTn(RSTn), .cfg_arm(cfg_arm), .cfg_abort(cfg_abort),
        .cfg_target_reg(cfg_target_reg), .cfg_mask(cfg_mask), .cfg_delay(cfg_delay),
`ifdef FI_STUCK_AT_EN
        .cfg_mode(cfg_mode),
`endif
        .cpu_running(cpu_running), .inj_stall(inj_stall), .regfile_addr(regfile_addr),
        .regfile_read_data(regfile_read_data), .regfile_write_enable(regfile_write_enable),
        .regfile_write_data(regfile_write_data), .busy(busy), .done(done), .err(err),
        .orig_value(orig_value), .inj_count(inj_count)
    );

    fault_inject_sequencer #(.COUNT_WIDTH(3)) dut_wrap (
        .CLK(CLK), .RSTn(RSTn), .cfg_arm(cfg_arm), .cfg_abort(cfg_abort),
        .cfg_target_reg(cfg_target_reg), .cfg_mask(cfg_mask), .cfg_delay(cfg_delay),
`ifdef FI_STUCK_AT_EN
        .cfg_mode(cfg_mode),
`endif
        .cpu_running(cpu_running), .inj_stall(w_inj_stall), .regfile_addr(w_regfile_addr),
        .regfile_read_data(w_regfile_read_data), .regfile_write_enable(w_regfile_write_enable),
        .regfile_write_data(w_regfile_write_data), .busy(w_busy), .done(w_done), .err(w_err),
        .orig_value(w_orig_value), .inj_count(w_inj_count)
    );

    // Record register-file writes and done pulses seen by the main instance.
    always @(posedge CLK) begin
        if (regfile_write_enable) begin
            wr_cnt  <= wr_cnt + 1;
            wr_addr <= regfile_addr;
            wr_data <= regfile_write_data;
        end
        if (done) begin
            done_cnt <= done_cnt + 1;
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic arm(input logic [4:0] t, input logic [31:0] m, input logic [31:0] d);
        cfg_target_reg = t;
        cfg_mask       = m;
        cfg_delay      = d;
        cfg_arm        = 1'b1;
        tick();
        cfg_arm        = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int n;
        n = 0;
        while (done !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        check(tag, done, 1);
    endtask

    task automatic inject(input logic [4:0] t, input logic [31:0] m, input logic [31:0] d);
        arm(t, m, d);
        wait_done("inject_done");
        exp_cnt++;
        tick();
    endtask

    initial begin
        for (int i = 0; i < 32; i++) rf_val[i] = 32'h0;
        rf_val[1] = 32'h0000_1000;
        rf_val[3] = 32'h1111_1111;
        rf_val[4] = 32'h4444_4444;
        rf_val[5] = 32'hA5A5_A5A4;
        rf_val[6] = 32'h0000_0000;
        rf_val[7] = 32'hDEAD_BEEF;
        rf_val[8] = 32'h1234_5678;
        rf_val[9] = 32'h0000_00F0;
        pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b0; pat[3] = 1'b1;
        pat[4] = 1'b1; pat[5] = 1'b0; pat[6] = 1'b1;

        RSTn = 1'b0; cfg_arm = 1'b0; cfg_abort = 1'b0; cfg_target_reg = '0;
        cfg_mask = '0; cfg_delay = '0; cpu_running = 1'b1;
`ifdef FI_STUCK_AT_EN
        cfg_mode = 2'd0;
`endif
        tick();
        tick();
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_stall", inj_stall, 0);
        check("rst_we", regfile_write_enable, 0);
        check("rst_addr", regfile_addr, 0);
        check("rst_wdata", regfile_write_data, 0);
        check("rst_err", err, 0);
        check("rst_orig", orig_value, 0);
        check("rst_count", inj_count, 0);
        RSTn = 1'b1;
        tick();

        // Reset in the middle of a sequence releases the stall with no write.
        arm(5'd5, 32'h1, 32'd0);
        tick();
        check("midrst_stall_before", inj_stall, 1);
        RSTn = 1'b0;
        tick();
        RSTn = 1'b1;
        check("midrst_stall", inj_stall, 0);
        check("midrst_busy", busy, 0);
        check("midrst_nowrite", wr_cnt, 0);
        tick();

        // Basic flip: done exactly 8 cycles after arm.
        arm(5'd5, 32'h0000_0001, 32'd3);
        for (int c = 1; c <= 8; c++) begin
            check("basic_done", done, (c == 8));
            if (c == 5) check("basic_stall", inj_stall, 1);
            if (c == 6) check("basic_raddr", regfile_addr, 5);
            if (c == 7) begin
                check("basic_we", regfile_write_enable, 1);
                check("basic_waddr", regfile_addr, 5);
                check("basic_wdata", regfile_write_data, 32'hA5A5_A5A5);
            end
            if (c < 8) tick();
        end
        exp_cnt++;
        tick();
        check("basic_orig", orig_value, 32'hA5A5_A5A4);
        check("basic_count", inj_count, 1);
        check("basic_idle", busy, 0);
        check("basic_we_idle", regfile_write_enable, 0);

        // Counting only advances on cpu_running cycles.
        arm(5'd6, 32'h8000_0000, 32'd4);
        for (int i = 0; i < 7; i++) begin
            cpu_running = pat[i];
            check("stallcnt_nostall", inj_stall, 0);
            tick();
        end
        check("stallcnt_last_count", inj_stall, 0);
        check("stallcnt_busy", busy, 1);
        cpu_running = 1'b1;
        tick();
        check("stallcnt_stall", inj_stall, 1);
        wait_done("stallcnt_done");
        exp_cnt++;
        tick();
        check("stallcnt_wdata", wr_data, 32'h8000_0000);
        check("stallcnt_waddr", wr_addr, 6);

        // Abort during COUNT cancels without touching the register file.
        wc = wr_cnt;
        dc = done_cnt;
        arm(5'd4, 32'hFFFF_FFFF, 32'd100);
        for (int i = 0; i < 9; i++) tick();
        check("abort_busy_before", busy, 1);
        cfg_abort = 1'b1;
        tick();
        cfg_abort = 1'b0;
        check("abort_idle", busy, 0);
        tick();
        tick();
        check("abort_nowrite", wr_cnt, wc);
        check("abort_nodone", done_cnt, dc);
        check("abort_count", inj_count, exp_cnt);

        // Abort while in READ is ignored.
        arm(5'd8, 32'hFFFF_0000, 32'd0);
        tick();
        tick();
        check("abort_read_addr", regfile_addr, 8);
        cfg_abort = 1'b1;
        tick();
        cfg_abort = 1'b0;
        check("abort_read_we", regfile_write_enable, 1);
        check("abort_read_wdata", regfile_write_data, 32'hEDCB_5678);
        tick();
        check("abort_read_done", done, 1);
        exp_cnt++;
        tick();

        // Illegal arm, then an arm while busy is ignored.
        arm(5'd0, 32'h1, 32'd0);
        check("illegal_err", err, 1);
        check("illegal_busy", busy, 0);
        arm(5'd3, 32'h0000_FF00, 32'd2);
        check("legal_err_clr", err, 0);
        check("legal_busy", busy, 1);
        arm(5'd7, 32'hFFFF_FFFF, 32'd0);
        check("busyarm_busy", busy, 1);
        arm(5'd0, 32'h1, 32'd0);
        check("busyarm_err", err, 0);
        wait_done("busyarm_done");
        exp_cnt++;
        tick();
        check("busyarm_waddr", wr_addr, 3);
        check("busyarm_wdata", wr_data, 32'h1111_EE11);

        // Delay zero: STALL on the cycle after COUNT; also clears a fresh err.
        arm(5'd0, 32'h1, 32'd0);
        check("illegal2_err", err, 1);
        arm(5'd7, 32'h0000_000F, 32'd0);
        check("d0_err_clr", err, 0);
        check("d0_count_state", inj_stall, 0);
        tick();
        check("d0_stall", inj_stall, 1);
        wait_done("d0_done");
        exp_cnt++;
        tick();
        check("d0_wdata", wr_data, 32'hDEAD_BEE0);

`ifdef FI_STUCK_AT_EN
        cfg_mode = 2'd1;
        arm(5'd9, 32'h0000_0F0F, 32'd1);
        wait_done("sa1_done");
        exp_cnt++;
        tick();
        check("sa1_wdata", wr_data, 32'h0000_0FFF);
        cfg_mode = 2'd2;
        arm(5'd9, 32'h0000_0F0F, 32'd1);
        wait_done("sa0_done");
        exp_cnt++;
        tick();
        check("sa0_wdata", wr_data, 32'h0000_00F0);
        wc = wr_cnt;
        cfg_mode = 2'd3;
        arm(5'd9, 32'h0000_0F0F, 32'd1);
        check("mode3_err", err, 1);
        check("mode3_busy", busy, 0);
        tick();
        check("mode3_nowrite", wr_cnt, wc);
        cfg_mode = 2'd0;
`endif

        // Counter wrap, checked on a narrow-counter instance.
        while ((exp_cnt % 8) != 7) inject(5'd1, 32'h1, 32'd0);
        check("wrap_pre", w_inj_count, 7);
        inject(5'd1, 32'h1, 32'd0);
        check("wrap_zero", w_inj_count, 0);
        check("main_count", inj_count, exp_cnt);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/fault_inject_sequencer.md
Name: fault_inject_sequencer

Overview:
Hardware sequencer that performs one timed register-file fault injection per arm command. It counts CPU-running cycles after arming, then requests a CPU stall. While stalled it does a read-modify-write on one architectural register: it reads the register, applies the configured bit mask and writes the result back. It then releases the stall. It sits between the control/config registers (driven from the PS over AXI) and a second register-file access port, alongside the PS debug path.

Parameters:
DATA_WIDTH, 32, register and mask width
REG_ADDR_WIDTH, 5, register-file index width
DELAY_WIDTH, 32, width of injection delay counter
COUNT_WIDTH, 16, width of completed-injection counter

Ports:
CLK  in  1  core clock
RSTn  in  1  synchronous active-low reset
cfg_arm  in  1  single-cycle pulse; starts a sequence
cfg_abort  in  1  single-cycle pulse; cancels a pending (counting) sequence
cfg_target_reg  in  REG_ADDR_WIDTH  register to corrupt, sampled on arm
cfg_mask  in  DATA_WIDTH  fault bit mask, sampled on arm
cfg_delay  in  DELAY_WIDTH  CPU-running cycles before injection, sampled on arm
cpu_running  in  1  high when the core clock-enable is active (not stalled by anyone)
inj_stall  out  DATA_WIDTH?no: 1  stall request to core, ORed with the debug stall
regfile_addr  out  REG_ADDR_WIDTH  register-file port address
regfile_read_data  in  DATA_WIDTH  asynchronous read data for regfile_addr
regfile_write_enable  out  1  write strobe
regfile_write_data  out  DATA_WIDTH  write data
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse when the injection has been written
err  out  1  sticky; set on an illegal arm, cleared on the next legal arm
orig_value  out  DATA_WIDTH  register value captured before the fault
inj_count  out  COUNT_WIDTH  number of completed injections

Behaviour:
- Clock and reset: one clock, CLK. Reset is RSTn, synchronous and active-low.
- Reset values: state=IDLE; all outputs 0; orig_value=0; inj_count=0; err=0.
- States: IDLE, COUNT, STALL, READ, WRITE, RELEASE.
- IDLE, on cfg_arm:
  - cfg_target_reg==0: set err, stay in IDLE.
  - Otherwise: latch target, mask and delay into internal registers, clear err, go to COUNT.
- COUNT:
  - Counter==0 → STALL (delay 0 gives STALL on the next cycle).
  - Else, if cpu_running, decrement; otherwise hold.
  - cfg_abort → IDLE with no regfile access. Abort has priority over the zero check.
- STALL: inj_stall=1; one settle cycle for in-flight instruction retirement → READ.
- READ: inj_stall=1; regfile_addr=target; orig_value<=regfile_read_data at the clock edge → WRITE.
- WRITE: inj_stall=1; regfile_addr=target; regfile_write_enable=1; regfile_write_data=orig_value ^ mask → RELEASE.
- RELEASE: inj_stall=0; done=1; inj_count<=inj_count+1, wrapping at all-ones to 0 → IDLE.
- Latency: arm to done = delay counted cycles + 5 cycles when cpu_running stays high.
- Command handling while busy:
  - cfg_arm outside IDLE is ignored and config is not re-sampled.
  - cfg_abort in STALL, READ, WRITE or RELEASE is ignored; the read-modify-write is atomic.
  - Simultaneous arm and abort in IDLE: arm wins.
- Output decoding:
  - inj_stall, regfile_* and done are decoded combinationally from the state register only; no combinational path from cfg_* inputs.
  - regfile_addr, regfile_write_enable and regfile_write_data are 0 outside READ/WRITE.
- Reset mid-sequence returns to IDLE next edge with inj_stall released; a partial write cannot occur because the write is one cycle.
- The caller must keep the debug path off the regfile port while busy; this block does not arbitrate.

Optional Feature:
FI_STUCK_AT_EN
- Defined: adds input cfg_mode (width 2), sampled on arm, which selects the fault type:
  - 0: flip, orig ^ mask
  - 1: stuck-at-1, orig | mask
  - 2: stuck-at-0, orig & ~mask
  - 3: illegal; sets err on arm and stays in IDLE
- Undefined: the cfg_mode port is absent and the fault is always XOR.

Test Plan:
- Basic flip: arm target=5, mask=0x0000_0001, delay=3, cpu_running=1, x5=0xA5A5_A5A4 → 3 COUNT decrements then STALL; write 0xA5A5_A5A5 to x5; orig_value=0xA5A5_A5A4; done at cycle 8 after arm; inj_count=1.
- Stalled counting: delay=4, cpu_running toggles 1,0,0,1,1,0,1 → STALL entered only after 4 high cycles; inj_stall=0 throughout COUNT.
- Abort: arm delay=100, abort at cycle 10 → IDLE, regfile_write_enable never asserted, done never pulses, inj_count unchanged; abort issued in READ → ignored, write still occurs.
- Illegal/busy arm: arm target=0 → err=1, busy=0; then arm while in COUNT with target=7 → ignored, original target written; next legal arm clears err.
- Delay zero and wrap: delay=0 → STALL on the cycle after arm; preload inj_count=0xFFFF by 65535 injections (or force) → next done makes inj_count=0x0000.
- FI_STUCK_AT_EN: x9=0x0000_00F0, mask=0x0000_0F0F; mode 1 → 0x0000_0FFF; mode 2 → 0x0000_00F0; mode 3 → err=1, no write.
